// File: rtl/frame_painter_pkg.sv
// frame_painter_pkg: shared geometry, FSM encoding and sprite ROM contents for the frame painter.
package frame_painter_pkg;
  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int SPR_W = 16;
  localparam int SPR_H = 16;
  localparam logic [4:0] SPR_NONE = 5'd31;
  localparam logic [11:0] TRANSP = 12'hF0F;
  localparam int X_MSB = 16;
  localparam int X_LSB = 8;
  localparam int Y_MSB = 7;
  typedef enum logic [2:0] {IDLE, SNAP, CLEAR, SPR_SETUP, SPR_DRAW, SPR_DRAIN, DONE} state_t;
  // Texel at {id, sy, sx}: colour is {id[3:0]^{id[4],000}, sy, sx}; id 15 texel (sy0,sx15) is TRANSP.
  function automatic logic [11:0] sprite_texel(input logic [12:0] a);
    return a[11:0] ^ {a[12], 11'b0};
  endfunction
endpackage

// File: rtl/frame_painter_sprite_rom.sv
// sprite_rom: synchronous 8192x12 sprite texture ROM (32 ids x 256 texels), one-cycle read latency.
module sprite_rom
  import frame_painter_pkg::*;
(
  input  logic        clk,
  input  logic [12:0] addr,
  output logic [11:0] q
);
  always_ff @(posedge clk) q <= sprite_texel(addr);
endmodule

// File: rtl/frame_painter.sv
// frame_painter: repaints a 320x240 frame (background flood, then six 16x16 sprites) one pixel per cycle.
// Define SPRITE_TRANSPARENCY_EN to suppress writes of TRANSP-coloured texels.
module frame_painter
  import frame_painter_pkg::*;
(
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        redraw,
  input  logic [11:0] background,
  input  logic [1:0]  Screen,
  input  logic [4:0]  ob1a, ob1b, ob2a, ob2b, ob3a, ob3b,
  input  logic [16:0] ob1axy, ob1bxy, ob2axy, ob2bxy, ob3axy, ob3bxy,
  output logic [8:0]  x,
  output logic [7:0]  y,
  output logic [11:0] colour,
  output logic        plot,
  output logic        busy,
  output logic        done
);
  state_t state;
  logic pending, plot_r, src_rom, trig, nfound, inb;
  logic [11:0] bg_q, colour_r, rom_q;
  logic [1:0] scr_q;
  logic [5:0][4:0] id_s;
  logic [5:0][16:0] xy_s;
  logic [2:0] k, nidx;
  logic [4:0] id_c;
  logic [8:0] ox;
  logic [7:0] oy;
  logic [3:0] sx, sy;
  logic [9:0] xs;
  logic [8:0] ys;
  // Change detect and frame snapshot are unreset so no spurious trigger follows reset release.
  always_ff @(posedge CLOCK_50) begin
    bg_q <= background;
    scr_q <= Screen;
    if (state == SNAP) begin
      id_s <= {ob3b, ob3a, ob2b, ob2a, ob1b, ob1a};
      xy_s <= {ob3bxy, ob3axy, ob2bxy, ob2axy, ob1bxy, ob1axy};
    end
  end
  assign trig = redraw | (background != bg_q) | (Screen != scr_q);
  always_comb begin
    nfound = 1'b0;
    nidx = 3'd0;
    for (int j = 5; j >= 0; j--)
      if (3'(j) >= k && id_s[j] != SPR_NONE) begin
        nfound = 1'b1;
        nidx = 3'(j);
      end
  end
  assign xs = {1'b0, ox} + {6'b0, sx};
  assign ys = {1'b0, oy} + {5'b0, sy};
  assign inb = xs < 10'(SCREEN_W) && ys < 9'(SCREEN_H);
  sprite_rom u_rom (.clk(CLOCK_50), .addr({id_c, sy, sx}), .q(rom_q));
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      pending <= 1'b1;
      k <= '0;
      id_c <= '0;
      ox <= '0;
      oy <= '0;
      sx <= '0;
      sy <= '0;
      x <= '0;
      y <= '0;
      colour_r <= '0;
      plot_r <= 1'b0;
      src_rom <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      pending <= trig | (pending & (state != IDLE));
      done <= 1'b0;
      case (state)
        IDLE: if (pending) begin
          state <= SNAP;
          busy <= 1'b1;
        end
        SNAP: begin
          state <= CLEAR;
          x <= '0;
          y <= '0;
          plot_r <= 1'b1;
          colour_r <= background;
        end
        CLEAR: if (x == 9'(SCREEN_W - 1)) begin
          x <= '0;
          if (y == 8'(SCREEN_H - 1)) begin
            plot_r <= 1'b0;
            k <= '0;
            state <= SPR_SETUP;
          end else y <= y + 8'd1;
        end else x <= x + 9'd1;
        SPR_SETUP: if (nfound) begin
          id_c <= id_s[nidx];
          ox <= xy_s[nidx][X_MSB:X_LSB];
          oy <= xy_s[nidx][Y_MSB:0];
          k <= nidx + 3'd1;
          sx <= '0;
          sy <= '0;
          state <= SPR_DRAW;
        end else begin
          done <= 1'b1;
          state <= DONE;
        end
        SPR_DRAW: begin
          // Coordinates and strobe ride alongside the ROM read so they line up with rom_q.
          x <= xs[8:0];
          y <= ys[7:0];
          plot_r <= inb;
          src_rom <= 1'b1;
          sx <= sx + 4'd1;
          if (sx == 4'(SPR_W - 1)) sy <= sy + 4'd1;
          if (sx == 4'(SPR_W - 1) && sy == 4'(SPR_H - 1)) state <= SPR_DRAIN;
        end
        SPR_DRAIN: begin
          plot_r <= 1'b0;
          src_rom <= 1'b0;
          done <= !nfound;
          state <= nfound ? SPR_SETUP : DONE;
        end
        DONE: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign colour = src_rom ? rom_q : colour_r;
`ifdef SPRITE_TRANSPARENCY_EN
  assign plot = plot_r & ~(src_rom & (rom_q == TRANSP));
`else
  assign plot = plot_r;
`endif
endmodule
